// File: rtl/regfile_pkg.sv
// Shared constants and the clear-sequencer state encoding for the register bank.
package regfile_pkg;

    localparam int ADDR_W = 5;
    localparam logic [ADDR_W-1:0] REG_ZERO = '0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_DONE  = 2'd2
    } clr_state_e;

endpackage

// File: rtl/regfile_clear_seq.sv
// Hardware clear sequencer: walks x1..x(NREGS-1) one register per cycle and
// overrides the bank's write port while doing so.
module regfile_clear_seq
    import regfile_pkg::*;
#(
    parameter int NREGS = 16,
    parameter int IDX_W = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_req,
    output logic             clr_we,
    output logic [IDX_W-1:0] clr_addr,
    output logic             clr_busy,
    output logic             clr_done
);

    localparam logic [IDX_W-1:0] IDX_FIRST = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NREGS - 1);

    clr_state_e       state;
    logic [IDX_W-1:0] index;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            index    <= IDX_FIRST;
            clr_busy <= 1'b0;
            clr_done <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    clr_done <= 1'b0;
                    if (clr_req) begin
                        state    <= ST_CLEAR;
                        index    <= IDX_FIRST;
                        clr_busy <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    if (index == IDX_LAST) begin
                        state    <= ST_DONE;
                        index    <= IDX_FIRST;
                        clr_busy <= 1'b0;
                        clr_done <= 1'b1;
                    end else begin
                        index <= index + IDX_W'(1);
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    clr_done <= 1'b0;
                end
            endcase
        end
    end

    // clr_busy is high exactly while in CLEAR, so it doubles as the write strobe.
    assign clr_we   = clr_busy;
    assign clr_addr = index;

endmodule

// File: rtl/register_bank.sv
// RISC-V integer register bank with per-register scoreboard bits and a clear
// sequencer. Define REGFILE_BYPASS_EN to forward same-cycle writes to reads.
module register_bank
    import regfile_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int NREGS = 16,
    parameter int NRP   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     rd,
    input  logic [XLEN-1:0]       rd_data,
    input  logic [NRP*ADDR_W-1:0] rs_addr,
    output logic [NRP*XLEN-1:0]   rs_data,
    output logic [NRP-1:0]        rs_busy,
    input  logic                  sb_set,
    input  logic [ADDR_W-1:0]     sb_addr,
    input  logic                  clr_req,
    output logic                  clr_busy,
    output logic                  clr_done
);

    localparam int IDX_W = $clog2(NREGS);

    function automatic logic addr_valid(input logic [ADDR_W-1:0] a);
        return (a != REG_ZERO) && (32'(a) < NREGS);
    endfunction

    logic [XLEN-1:0]  regs [NREGS];
    logic [NREGS-1:0] busy;
    logic             clr_we;
    logic [IDX_W-1:0] clr_addr;

    regfile_clear_seq #(
        .NREGS (NREGS),
        .IDX_W (IDX_W)
    ) u_clear_seq (
        .clk      (clk),
        .rst      (rst),
        .clr_req  (clr_req),
        .clr_we   (clr_we),
        .clr_addr (clr_addr),
        .clr_busy (clr_busy),
        .clr_done (clr_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: reset must zero architectural state, so this array is flops, not an inferable RAM.
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
            busy <= '0;
        end else if (clr_we) begin
            regs[clr_addr] <= '0;
            busy[clr_addr] <= 1'b0;
        end else begin
            if (we && addr_valid(rd)) begin
                regs[rd[IDX_W-1:0]] <= rd_data;
                busy[rd[IDX_W-1:0]] <= 1'b0;
            end
            // NOTE: non-blocking, so this later assignment wins on a same-address collision (set wins).
            if (sb_set && addr_valid(sb_addr)) begin
                busy[sb_addr[IDX_W-1:0]] <= 1'b1;
            end
        end
    end

    for (genvar k = 0; k < NRP; k++) begin : g_read
        logic [ADDR_W-1:0] addr;
        logic [XLEN-1:0]   data;
        logic              pend;

        assign addr = rs_addr[ADDR_W*k +: ADDR_W];

        always_comb begin
            // NOTE: defaults first, so every path assigns data/pend and no latch is inferred.
            data = '0;
            pend = 1'b0;
            if (addr_valid(addr)) begin
                data = regs[addr[IDX_W-1:0]];
                pend = busy[addr[IDX_W-1:0]];
`ifdef REGFILE_BYPASS_EN
                if (we && !clr_busy && (addr == rd)) begin
                    data = rd_data;
                    pend = sb_set && (sb_addr == addr);
                end
`endif
            end
        end

        assign rs_data[XLEN*k +: XLEN] = data;
        assign rs_busy[k]              = pend;
    end

endmodule

// File: tb/tb_register_bank.sv
// Self-checking bench for register_bank: directed scenarios plus randomized
// traffic against an array-based architectural model.
module tb_register_bank;

    localparam int XLEN  = 32;
    localparam int NREGS = 16;
    localparam int NRP   = 2;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                we = 1'b0;
    logic [4:0]          rd = '0;
    logic [XLEN-1:0]     rd_data = '0;
    logic [NRP*5-1:0]    rs_addr = '0;
    logic [NRP*XLEN-1:0] rs_data;
    logic [NRP-1:0]      rs_busy;
    logic                sb_set = 1'b0;
    logic [4:0]          sb_addr = '0;
    logic                clr_req = 1'b0;
    logic                clr_busy;
    logic                clr_done;

    int total = 0;
    int bad   = 0;

    logic [XLEN-1:0] m_regs [32];
    logic            m_busy [32];

    register_bank #(
        .XLEN  (XLEN),
        .NREGS (NREGS),
        .NRP   (NRP)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .we       (we),
        .rd       (rd),
        .rd_data  (rd_data),
        .rs_addr  (rs_addr),
        .rs_data  (rs_data),
        .rs_busy  (rs_busy),
        .sb_set   (sb_set),
        .sb_addr  (sb_addr),
        .clr_req  (clr_req),
        .clr_busy (clr_busy),
        .clr_done (clr_done)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    function automatic bit is_valid(input int a);
        return (a != 0) && (a < NREGS);
    endfunction

    // Architectural view of a read given the inputs presented this cycle.
    function automatic logic [XLEN-1:0] exp_data(input int a);
        if (!is_valid(a)) return '0;
`ifdef REGFILE_BYPASS_EN
        if (we && a == int'(rd)) return rd_data;
`endif
        return m_regs[a];
    endfunction

    function automatic logic exp_busy(input int a);
        if (!is_valid(a)) return 1'b0;
`ifdef REGFILE_BYPASS_EN
        if (we && a == int'(rd)) return sb_set && (int'(sb_addr) == a);
`endif
        return m_busy[a];
    endfunction

    task automatic model_zero();
        for (int i = 0; i < 32; i++) begin
            m_regs[i] = '0;
            m_busy[i] = 1'b0;
        end
    endtask

    task automatic model_commit();
        if (we && is_valid(int'(rd))) begin
            m_regs[rd] = rd_data;
            m_busy[rd] = 1'b0;
        end
        if (sb_set && is_valid(int'(sb_addr))) m_busy[sb_addr] = 1'b1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        we      = 1'b0;
        sb_set  = 1'b0;
        clr_req = 1'b0;
    endtask

    task automatic fill_regs();
        for (int a = 1; a < NREGS; a++) begin
            we      = 1'b1;
            rd      = 5'(a);
            rd_data = $urandom;
            sb_set  = 1'b1;
            sb_addr = 5'(a);
            model_commit();
            step();
        end
        idle_inputs();
    endtask

    task automatic test_reset();
        rs_addr = {5'd2, 5'd1};
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++;
        if (clr_busy !== 1'b0) begin bad++; $display("FAIL reset_clr_busy got=%b want=0", clr_busy); end
        total++;
        if (clr_done !== 1'b0) begin bad++; $display("FAIL reset_clr_done got=%b want=0", clr_done); end
        total++;
        if (rs_data !== '0) begin bad++; $display("FAIL reset_rs_data got=%h want=0", rs_data); end
        total++;
        if (rs_busy !== '0) begin bad++; $display("FAIL reset_rs_busy got=%b want=0", rs_busy); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_write_read();
        we = 1'b1; rd = 5'd5; rd_data = 32'hDEADBEEF; rs_addr = '0;
        model_commit();
        step();
        idle_inputs();
        rs_addr = {5'd0, 5'd5};
        @(negedge clk);
        total++;
        if (rs_data[31:0] !== 32'hDEADBEEF) begin bad++; $display("FAIL wr_rd_data got=%h want=deadbeef", rs_data[31:0]); end
        total++;
        if (rs_busy[0] !== 1'b0) begin bad++; $display("FAIL wr_rd_busy got=%b want=0", rs_busy[0]); end
        step();
    endtask

    task automatic test_invalid();
        we = 1'b1; rd = 5'd0;  rd_data = 32'hFFFF_FFFF; sb_set = 1'b1; sb_addr = 5'd0;
        model_commit(); step();
        rd = 5'd20; rd_data = 32'h1234_5678; sb_addr = 5'd20;
        model_commit(); step();
        idle_inputs();
        for (int a = 0; a < 16; a++) begin
            rs_addr = {5'(a + 16), 5'(a)};
            @(negedge clk);
            for (int k = 0; k < NRP; k++) begin
                int ad = int'(rs_addr[5*k +: 5]);
                total++;
                if (rs_data[XLEN*k +: XLEN] !== exp_data(ad) || rs_busy[k] !== exp_busy(ad)) begin
                    bad++;
                    $display("FAIL invalid_addr addr=%0d got=%h/%b want=%h/%b", ad,
                             rs_data[XLEN*k +: XLEN], rs_busy[k], exp_data(ad), exp_busy(ad));
                end
            end
            step();
        end
    endtask

    task automatic test_scoreboard();
        sb_set = 1'b1; sb_addr = 5'd7;
        model_commit(); step();
        idle_inputs();
        rs_addr = {5'd7, 5'd0};
        @(negedge clk);
        total++;
        if (rs_busy[1] !== 1'b1) begin bad++; $display("FAIL sb_set got=%b want=1", rs_busy[1]); end
        step();
        sb_set = 1'b1; sb_addr = 5'd7; we = 1'b1; rd = 5'd7; rd_data = 32'h77;
        model_commit(); step();
        idle_inputs();
        @(negedge clk);
        total++;
        if (rs_busy[1] !== 1'b1) begin bad++; $display("FAIL sb_set_wins got=%b want=1", rs_busy[1]); end
        total++;
        if (rs_data[63:32] !== 32'h77) begin bad++; $display("FAIL sb_set_wins_data got=%h want=77", rs_data[63:32]); end
        step();
        we = 1'b1; rd = 5'd7; rd_data = 32'h78;
        model_commit(); step();
        idle_inputs();
        @(negedge clk);
        total++;
        if (rs_busy[1] !== 1'b0) begin bad++; $display("FAIL sb_clear_by_we got=%b want=0", rs_busy[1]); end
        step();
    endtask

    task automatic test_bypass();
        logic [XLEN-1:0] want_d;
        logic            want_b;
        we = 1'b1; rd = 5'd3; rd_data = 32'h55; sb_set = 1'b1; sb_addr = 5'd3;
        model_commit(); step();
        sb_set = 1'b0; we = 1'b1; rd = 5'd3; rd_data = 32'h12;
        rs_addr = {5'd0, 5'd3};
`ifdef REGFILE_BYPASS_EN
        want_d = 32'h12; want_b = 1'b0;
`else
        want_d = 32'h55; want_b = 1'b1;
`endif
        @(negedge clk);
        total++;
        if (rs_data[31:0] !== want_d) begin bad++; $display("FAIL bypass_data got=%h want=%h", rs_data[31:0], want_d); end
        total++;
        if (rs_busy[0] !== want_b) begin bad++; $display("FAIL bypass_busy got=%b want=%b", rs_busy[0], want_b); end
        model_commit(); step();
        idle_inputs();
        @(negedge clk);
        total++;
        if (rs_data[31:0] !== 32'h12) begin bad++; $display("FAIL bypass_next got=%h want=12", rs_data[31:0]); end
        total++;
        if (rs_busy[0] !== 1'b0) begin bad++; $display("FAIL bypass_next_busy got=%b want=0", rs_busy[0]); end
        step();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            we      = 1'($urandom_range(0, 1));
            rd      = 5'($urandom_range(0, 31));
            rd_data = $urandom;
            sb_set  = 1'($urandom_range(0, 1));
            sb_addr = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31));
            rs_addr = {5'($urandom_range(0, 31)), ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31))};
            @(negedge clk);
            for (int k = 0; k < NRP; k++) begin
                int ad = int'(rs_addr[5*k +: 5]);
                total++;
                if (rs_data[XLEN*k +: XLEN] !== exp_data(ad)) begin
                    bad++;
                    $display("FAIL rand_data cyc=%0d port=%0d addr=%0d got=%h want=%h", c, k, ad,
                             rs_data[XLEN*k +: XLEN], exp_data(ad));
                end
                total++;
                if (rs_busy[k] !== exp_busy(ad)) begin
                    bad++;
                    $display("FAIL rand_busy cyc=%0d port=%0d addr=%0d got=%b want=%b", c, k, ad,
                             rs_busy[k], exp_busy(ad));
                end
            end
            model_commit();
            step();
        end
        idle_inputs();
    endtask

    task automatic test_clear();
        int busy_cnt = 0;
        int done_cnt = 0;
        logic [XLEN-1:0] top_val;
        fill_regs();
        top_val = m_regs[NREGS-1];
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (i == 2) begin we = 1'b1; rd = 5'd5; rd_data = 32'hAAAA5555; sb_set = 1'b1; sb_addr = 5'd6; end
            if (i == 3) begin we = 1'b0; sb_set = 1'b0; end
            clr_req = (i == 4);
            if (i == 5) rs_addr = {5'(NREGS - 1), 5'd1};
            @(negedge clk);
            if (clr_busy === 1'b1) busy_cnt++;
            if (clr_done === 1'b1) done_cnt++;
            if (i == 5) begin
                total++;
                if (rs_data[31:0] !== '0) begin bad++; $display("FAIL clear_mid_x1 got=%h want=0", rs_data[31:0]); end
                total++;
                if (rs_data[63:32] !== top_val) begin bad++; $display("FAIL clear_mid_top got=%h want=%h", rs_data[63:32], top_val); end
            end
            step();
        end
        idle_inputs();
        model_zero();
        total++;
        if (busy_cnt != NREGS - 1) begin bad++; $display("FAIL clear_busy_cycles got=%0d want=%0d", busy_cnt, NREGS - 1); end
        total++;
        if (done_cnt != 1) begin bad++; $display("FAIL clear_done_pulses got=%0d want=1", done_cnt); end
        for (int a = 0; a < 16; a++) begin
            rs_addr = {5'(a + 16), 5'(a)};
            @(negedge clk);
            for (int k = 0; k < NRP; k++) begin
                int ad = int'(rs_addr[5*k +: 5]);
                total++;
                if (rs_data[XLEN*k +: XLEN] !== exp_data(ad) || rs_busy[k] !== exp_busy(ad)) begin
                    bad++;
                    $display("FAIL clear_contents addr=%0d got=%h/%b want=%h/%b", ad,
                             rs_data[XLEN*k +: XLEN], rs_busy[k], exp_data(ad), exp_busy(ad));
                end
            end
            step();
        end
    endtask

    task automatic test_abort();
        int busy_cnt = 0;
        int done_cnt = 0;
        fill_regs();
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        repeat (3) step();
        #1;
        rst = 1'b1;
        #1;
        model_zero();
        total++;
        if (clr_busy !== 1'b0) begin bad++; $display("FAIL abort_clr_busy got=%b want=0", clr_busy); end
        total++;
        if (clr_done !== 1'b0) begin bad++; $display("FAIL abort_clr_done got=%b want=0", clr_done); end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (clr_busy === 1'b1) busy_cnt++;
            if (clr_done === 1'b1) done_cnt++;
        end
        total++;
        if (done_cnt != 0) begin bad++; $display("FAIL abort_no_done got=%0d want=0", done_cnt); end
        total++;
        if (busy_cnt != 0) begin bad++; $display("FAIL abort_no_busy got=%0d want=0", busy_cnt); end
        step();
        for (int a = 0; a < 16; a++) begin
            rs_addr = {5'(a + 16), 5'(a)};
            @(negedge clk);
            for (int k = 0; k < NRP; k++) begin
                int ad = int'(rs_addr[5*k +: 5]);
                total++;
                if (rs_data[XLEN*k +: XLEN] !== exp_data(ad) || rs_busy[k] !== exp_busy(ad)) begin
                    bad++;
                    $display("FAIL abort_contents addr=%0d got=%h/%b want=%h/%b", ad,
                             rs_data[XLEN*k +: XLEN], rs_busy[k], exp_data(ad), exp_busy(ad));
                end
            end
            step();
        end
    endtask

    initial begin
        model_zero();
        test_reset();
        test_write_read();
        test_invalid();
        test_scoreboard();
        test_bypass();
        test_random();
        test_clear();
        test_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/register_bank.md
REGISTER_BANK -- requirements
Module: register_bank

Interface
REQ-001 Parameter XLEN, default 32, data width in bits.
REQ-002 Parameter NREGS, default 16, architectural register count; legal values are 16 (RV32E) and 32 (RV32I).
REQ-003 Parameter NRP, default 2, number of read ports, range 1..4.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 we  input  1  write enable.
REQ-007 rd  input  5  write address.
REQ-008 rd_data  input  XLEN  write data.
REQ-009 rs_addr  input  NRP*5  read addresses; port k occupies bits [5k+4:5k].
REQ-010 rs_data  output  NRP*XLEN  read data; port k occupies bits [XLEN*k+XLEN-1:XLEN*k].
REQ-011 rs_busy  output  NRP  scoreboard pending flag per read port.
REQ-012 sb_set  input  1  mark a register as pending writeback.
REQ-013 sb_addr  input  5  address marked by sb_set.
REQ-014 clr_req  input  1  request a hardware clear of all registers.
REQ-015 clr_busy  output  1  clear sequence in progress.
REQ-016 clr_done  output  1  one-cycle pulse when the clear sequence completes.

Function
REQ-017 An address is valid if it is nonzero and less than NREGS; x0 and out-of-range addresses SHALL read 0 with rs_busy 0, and writes or sb_set to them SHALL be ignored.
REQ-018 Reads SHALL be combinational (zero latency); a write SHALL become visible on the cycle after the write edge.
REQ-019 Each valid register SHALL carry one busy bit: sb_set sets it, and we to the same address clears it.
REQ-020 If sb_set and we target the same address in the same cycle, the busy bit SHALL end set (set wins).
REQ-021 Clear FSM states SHALL be IDLE, CLEAR and DONE; clr_req in IDLE SHALL move to CLEAR with the index at 1.
REQ-022 In CLEAR, each cycle SHALL write 0 to register[index], clear busy[index], and increment the index; at index NREGS-1 the FSM SHALL move to DONE.
REQ-023 DONE SHALL last one cycle with clr_done=1, then return to IDLE; clr_busy SHALL be 1 exactly in CLEAR (NREGS-1 cycles).
REQ-024 While clr_busy=1, we and sb_set SHALL be ignored (the sequencer has priority); clr_req SHALL be ignored outside IDLE.
REQ-025 Reads during CLEAR SHALL return the current stored contents, so already-cleared registers read 0.

Reset
REQ-026 Asserting rst SHALL, asynchronously, zero all registers and busy bits, force the FSM to IDLE with index 1, and drive clr_busy=0 and clr_done=0.
REQ-027 Asserting rst mid-clear SHALL abort the sequence; no clr_done pulse follows.
REQ-028 After reset release, operation SHALL start on the first rising clk edge.

Configuration
REQ-029 Macro REGFILE_BYPASS_EN defined: a read of a valid address equal to rd while we=1 and clr_busy=0 SHALL return rd_data, and rs_busy SHALL be 0 unless sb_set hits the same address in that cycle.
REQ-030 Macro REGFILE_BYPASS_EN undefined: such a read SHALL return the stored value and busy bit, with the new value visible next cycle.

Structure
REQ-031 Package regfile_pkg SHALL hold the address width 5, the REG_ZERO constant, and the clear FSM state encoding.
REQ-032 The clear FSM and index counter SHALL live in sub-module regfile_clear_seq, which drives the write port override, clr_busy and clr_done.

Verification
REQ-033 Reset, then we=1 rd=5 rd_data=0xDEADBEEF; next cycle rs_addr port0=5 -> rs_data0=0xDEADBEEF, rs_busy0=0.
REQ-034 NREGS=16: we to rd=0 and rd=20 -> reads of x0 and x20 return 0; no register is changed.
REQ-035 sb_set addr=7 -> rs_busy for x7 = 1 next cycle; then sb_set=1 and we=1 both on x7 -> busy stays 1; then we alone on x7 -> busy 0.
REQ-036 With REGFILE_BYPASS_EN, same-cycle we rd=3 data=0x12 and read x3 -> 0x12; without it -> old value, then 0x12 next cycle.
REQ-037 Fill x1..x15, pulse clr_req -> clr_busy high for 15 cycles, clr_done pulses once, all registers read 0, and a we issued during the clear is dropped.
REQ-038 Assert rst at clear cycle 4 -> all registers 0, clr_busy=0, and no clr_done pulse.
